// File: rtl/vga_fill_pkg.sv
// vga_fill_pkg
//   Shared encodings for the character-buffer fill engine.
//   - fill_mode_e  : region selection presented on char_buffer_fill.mode
//   - fill_state_e : engine FSM states
//   - mode_uses_col / mode_uses_row : which request fields a mode consumes
package vga_fill_pkg;

  typedef enum logic [1:0] {
    FILL_FULL      = 2'd0,  // whole screen
    FILL_LINE_TAIL = 2'd1,  // startCol..COLS-1 on startRow only
    FILL_ROWS      = 2'd2,  // full rows startRow..endRow
    FILL_TO_EOS    = 2'd3   // startCol/startRow through end of screen
  } fill_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  function automatic logic mode_uses_col(input fill_mode_e m);
    return (m == FILL_LINE_TAIL) || (m == FILL_TO_EOS);
  endfunction

  function automatic logic mode_uses_row(input fill_mode_e m);
    return (m != FILL_FULL);
  endfunction

endpackage

// File: rtl/fill_region_counter.sv
// fill_region_counter
//   Column/row position counter for the fill engine. Column is the fast
//   index; on reaching COLS-1 it returns to 0 and, when i_row_step is set,
//   the row advances. o_last flags the final position of the region.
// Ports:
//   clk, resetn        clock, synchronous active-low reset
//   i_load             load i_load_col / i_load_row (takes priority)
//   i_advance          step to the next position (one accepted write)
//   i_row_step         allow the row to advance on column wrap
//   i_row_check        0: last position is any row at col COLS-1
//   i_last_row         row that terminates the region when i_row_check=1
//   o_col, o_row       current position
//   o_last             current position is the final one of the region
module fill_region_counter #(
  parameter int COLS = 80,
  parameter int ROWS = 32,
  localparam int COL_W = $clog2(COLS),
  localparam int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [COL_W-1:0] i_load_col,
  input  logic [ROW_W-1:0] i_load_row,
  input  logic             i_advance,
  input  logic             i_row_step,
  input  logic             i_row_check,
  input  logic [ROW_W-1:0] i_last_row,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_last
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             w_col_end;

  assign w_col_end = (r_col == COL_MAX);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, matching the hardware.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_load) begin
      r_col <= i_load_col;
      r_row <= i_load_row;
    end else if (i_advance) begin
      if (w_col_end) begin
        r_col <= '0;
        if (i_row_step) begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_col_end && (!i_row_check || (r_row == i_last_row));

endmodule

// File: rtl/char_buffer_fill.sv
// char_buffer_fill
//   Request/acknowledge fill engine for the VGA text character buffer.
//   A start pulse in IDLE latches the request, then one write per cycle is
//   issued (address {col,row}) while wrReady accepts it. Data is either the
//   constant fillData or an incrementing pattern starting at 0.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   start                  request pulse, honoured only in IDLE
//   mode                   fill_mode_e region selection
//   startRow/endRow        row bounds (endRow used by FILL_ROWS only)
//   startCol               first column (FILL_LINE_TAIL, FILL_TO_EOS)
//   fillData, patternEn    constant value / incrementing-pattern select
//   abort                  cancel an active fill, no done pulse
//   wrReady                arbiter accepts the current write
//   wrEn, wrAddr, wrData   registered write request
//   busy                   fill in progress
//   done                   one-cycle pulse on normal completion
module char_buffer_fill
  import vga_fill_pkg::*;
#(
  parameter int COLS   = 80,
  parameter int ROWS   = 32,
  parameter int DATA_W = 7,
  localparam int COL_W  = $clog2(COLS),
  localparam int ROW_W  = $clog2(ROWS),
  localparam int ADDR_W = COL_W + ROW_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ROW_W-1:0]  startRow,
  input  logic [ROW_W-1:0]  endRow,
  input  logic [COL_W-1:0]  startCol,
  input  logic [DATA_W-1:0] fillData,
  input  logic              patternEn,
  input  logic              abort,
  input  logic              wrReady,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              busy,
  output logic              done
);

  fill_state_e       r_state;
  fill_state_e       w_state_next;
  fill_mode_e        r_mode;
  logic [ROW_W-1:0]  r_end_row;
  logic              r_pattern_en;
  logic [DATA_W-1:0] r_data;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;

  fill_mode_e        w_mode;
  logic              w_load;
  logic              w_accept;
  logic              w_empty;
  logic              w_row_oob;
  logic              w_col_oob;
  logic              w_last;
  logic              w_row_step;
  logic [ROW_W-1:0]  w_last_row;
  logic [COL_W-1:0]  w_load_col;
  logic [ROW_W-1:0]  w_load_row;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;

  assign w_mode   = fill_mode_e'(mode);
  assign w_load   = (r_state == ST_IDLE) && start;
  assign w_accept = (r_state == ST_RUN) && wrReady;

  // Compared as int so out-of-range column codes (e.g. 80..127) are caught.
  assign w_row_oob = (int'(startRow) >= ROWS);
  assign w_col_oob = (int'(startCol) >= COLS);

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and a latch cannot be inferred.
  always_comb begin
    w_empty = 1'b0;
    unique case (w_mode)
      FILL_FULL:                   w_empty = 1'b0;
      FILL_LINE_TAIL, FILL_TO_EOS: w_empty = w_row_oob || w_col_oob;
      FILL_ROWS:                   w_empty = w_row_oob || (endRow < startRow);
      default:                     w_empty = 1'b0;
    endcase
  end

  assign w_load_col = mode_uses_col(w_mode) ? startCol : '0;
  assign w_load_row = mode_uses_row(w_mode) ? startRow : '0;

  // Region shape comes from the latched mode so mid-fill input changes are
  // harmless. A line tail never steps the row: it ends at col COLS-1.
  assign w_row_step = (r_mode != FILL_LINE_TAIL);
  assign w_last_row = (r_mode == FILL_ROWS) ? r_end_row : ROW_W'(ROWS - 1);

  // The final write does not advance, so the row never wraps past ROWS-1.
  fill_region_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_region (
    .clk         (clk),
    .resetn      (resetn),
    .i_load      (w_load),
    .i_load_col  (w_load_col),
    .i_load_row  (w_load_row),
    .i_advance   (w_accept && !w_last),
    .i_row_step  (w_row_step),
    .i_row_check (w_row_step),
    .i_last_row  (w_last_row),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_last      (w_last)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = w_empty ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        // Abort wins over a simultaneous final acceptance.
        if (abort) begin
          w_state_next = ST_IDLE;
        end else if (w_accept && w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state into flops so wrReady never
  // reaches wrEn combinationally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_wr_en <= (w_state_next == ST_RUN);
      r_busy  <= (w_state_next == ST_RUN);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mode       <= FILL_FULL;
      r_end_row    <= '0;
      r_pattern_en <= 1'b0;
      r_data       <= '0;
    end else if (w_load) begin
      r_mode       <= w_mode;
      r_end_row    <= endRow;
      r_pattern_en <= patternEn;
      r_data       <= patternEn ? '0 : fillData;
    end else if (w_accept && r_pattern_en) begin
      r_data <= r_data + DATA_W'(1);
    end
  end

  assign wrEn   = r_wr_en;
  assign wrAddr = {w_col, w_row};
  assign wrData = r_data;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_char_buffer_fill.sv
module tb_char_buffer_fill;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [1:0]  mode;
  logic [4:0]  startRow;
  logic [4:0]  endRow;
  logic [6:0]  startCol;
  logic [6:0]  fillData;
  logic        patternEn;
  logic        abort;
  logic        wrReady;
  logic        wrEn;
  logic [11:0] wrAddr;
  logic [6:0]  wrData;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];

  char_buffer_fill #(
    .COLS   (80),
    .ROWS   (32),
    .DATA_W (7)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .mode      (mode),
    .startRow  (startRow),
    .endRow    (endRow),
    .startCol  (startCol),
    .fillData  (fillData),
    .patternEn (patternEn),
    .abort     (abort),
    .wrReady   (wrReady),
    .wrEn      (wrEn),
    .wrAddr    (wrAddr),
    .wrData    (wrData),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Expected address sequence, written as nested screen loops.
  task automatic build_expected(input int m, input int sr, input int er, input int sc);
    exp_q.delete();
    case (m)
      0: for (int r = 0; r < 32; r++) for (int c = 0; c < 80; c++) exp_q.push_back(12'(c * 32 + r));
      1: if (sc < 80) for (int c = sc; c < 80; c++) exp_q.push_back(12'(c * 32 + sr));
      2: if (er >= sr) for (int r = sr; r <= er; r++) for (int c = 0; c < 80; c++) exp_q.push_back(12'(c * 32 + r));
      default: if (sc < 80) begin
        for (int c = sc; c < 80; c++) exp_q.push_back(12'(c * 32 + sr));
        for (int r = sr + 1; r < 32; r++) for (int c = 0; c < 80; c++) exp_q.push_back(12'(c * 32 + r));
      end
    endcase
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; mode = 2'd0; startRow = '0; endRow = '0;
    startCol = '0; fillData = '0; patternEn = 1'b0; abort = 1'b0; wrReady = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wrEn, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: wrEn/busy/done=%b expected 000", {wrEn, busy, done});
    end
    n_checks++;
    if (wrAddr !== 12'd0 || wrData !== 7'd0) begin
      n_fail++; $display("FAIL reset_data: addr=%h data=%h expected 000/00", wrAddr, wrData);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({wrEn, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: wrEn/busy/done=%b expected 000", {wrEn, busy, done});
    end
  endtask

  // Issues one request and follows it to done, checking every write.
  task automatic run_fill(input string name, input int m, input int sr, input int er,
                          input int sc, input logic [6:0] fd, input logic pat,
                          input bit toggle, input bit poke_start, input int exp_count,
                          input logic [11:0] exp_first, input logic [11:0] exp_last);
    int          cyc;
    int          idx;
    int          done_cyc;
    int          exp_done;
    bit          seen_done;
    bit          prev_stall;
    bit          ready_now;
    logic [11:0] first_a;
    logic [11:0] last_a;
    logic [11:0] prev_a;
    logic [6:0]  prev_d;
    logic [6:0]  exp_d;
    build_expected(m, sr, er, sc);
    @(negedge clk);
    mode = 2'(m); startRow = 5'(sr); endRow = 5'(er); startCol = 7'(sc);
    fillData = fd; patternEn = pat; wrReady = 1'b1; start = 1'b1;
    cyc = 0; idx = 0; done_cyc = -1; seen_done = 0; prev_stall = 0;
    first_a = 'x; last_a = 'x; prev_a = 'x; prev_d = 'x;
    while (!seen_done && cyc < 6000) begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (poke_start && cyc == 50) begin
        start = 1'b1; mode = 2'd0; startRow = 5'd0; startCol = 7'd0; patternEn = 1'b1;
      end
      if (done) begin
        seen_done = 1; done_cyc = cyc;
        n_checks++;
        if (wrEn !== 1'b0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL %s done_flags: wrEn=%b busy=%b expected 0/0", name, wrEn, busy);
        end
      end else if (wrEn === 1'b1) begin
        exp_d = pat ? 7'(idx) : fd;
        n_checks++;
        if (idx >= exp_q.size()) begin
          n_fail++; $display("FAIL %s extra_write: write %0d at addr %h, only %0d expected", name, idx, wrAddr, exp_q.size());
        end else if (wrAddr !== exp_q[idx]) begin
          n_fail++; $display("FAIL %s addr[%0d]: got %h expected %h", name, idx, wrAddr, exp_q[idx]);
        end
        n_checks++;
        if (wrData !== exp_d || busy !== 1'b1) begin
          n_fail++; $display("FAIL %s data[%0d]: got %h busy=%b expected %h busy=1", name, idx, wrData, busy, exp_d);
        end
        if (prev_stall) begin
          n_checks++;
          if (wrAddr !== prev_a || wrData !== prev_d) begin
            n_fail++; $display("FAIL %s stall_hold: got %h/%h expected %h/%h", name, wrAddr, wrData, prev_a, prev_d);
          end
        end
        ready_now = toggle ? (cyc % 2 == 1) : 1'b1;
        wrReady = ready_now;
        if (ready_now) begin
          if (idx == 0) first_a = wrAddr;
          last_a = wrAddr;
          idx++;
        end
        prev_stall = !ready_now; prev_a = wrAddr; prev_d = wrData;
      end else begin
        n_checks++; n_fail++;
        $display("FAIL %s stalled: cycle %0d wrEn=%b done=%b expected a write or done", name, cyc, wrEn, done);
        break;
      end
    end
    wrReady = 1'b1;
    n_checks++;
    if (!seen_done) begin
      n_fail++; $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
    end
    n_checks++;
    if (idx != exp_count) begin
      n_fail++; $display("FAIL %s write_count: got %0d expected %0d", name, idx, exp_count);
    end
    if (exp_count == 0) exp_done = 1;
    else exp_done = toggle ? 2 * exp_count : exp_count + 1;
    n_checks++;
    if (done_cyc != exp_done) begin
      n_fail++; $display("FAIL %s done_latency: got %0d expected %0d", name, done_cyc, exp_done);
    end
    if (exp_count > 0) begin
      n_checks++;
      if (first_a !== exp_first || last_a !== exp_last) begin
        n_fail++; $display("FAIL %s endpoints: got %h..%h expected %h..%h", name, first_a, last_a, exp_first, exp_last);
      end
    end
    repeat (3) begin
      @(negedge clk);
      start = 1'b0;
      n_checks++;
      if (wrEn !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL %s post_idle: wrEn=%b done=%b busy=%b expected 0/0/0", name, wrEn, done, busy);
      end
    end
  endtask

  // Cancels a full-screen fill at its 100th RUN cycle by abort or by reset.
  task automatic test_abort(input bit use_reset);
    string name;
    name = use_reset ? "reset_mid_fill" : "abort";
    @(negedge clk);
    mode = 2'd0; fillData = 7'h55; patternEn = 1'b0; wrReady = 1'b1; start = 1'b1;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    // 100th write is index 99: col 19, row 1.
    n_checks++;
    if (wrEn !== 1'b1 || wrAddr !== 12'd609 || wrData !== 7'h55) begin
      n_fail++; $display("FAIL %s cycle100: wrEn=%b addr=%0d data=%h expected 1/609/55", name, wrEn, wrAddr, wrData);
    end
    if (use_reset) resetn = 1'b0;
    else abort = 1'b1;
    @(negedge clk);
    resetn = 1'b1; abort = 1'b0;
    n_checks++;
    if (wrEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL %s stop: wrEn=%b busy=%b done=%b expected 0/0/0", name, wrEn, busy, done);
    end
    if (use_reset) begin
      n_checks++;
      if (wrAddr !== 12'd0 || wrData !== 7'd0) begin
        n_fail++; $display("FAIL %s outputs_cleared: addr=%h data=%h expected 000/00", name, wrAddr, wrData);
      end
    end
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (wrEn !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL %s quiet: wrEn=%b done=%b expected 0/0", name, wrEn, done);
      end
    end
    run_fill({name, "_restart"}, 1, 7, 0, 75, 7'h3A, 1'b0, 1'b0, 1'b0, 5,
             12'(75 * 32 + 7), 12'(79 * 32 + 7));
  endtask

  task automatic test_full();
    run_fill("full", 0, 0, 0, 0, 7'h00, 1'b0, 1'b0, 1'b0, 2560, 12'h000, 12'h9FF);
  endtask

  task automatic test_line_tail();
    run_fill("line_tail", 1, 5, 0, 70, 7'h00, 1'b1, 1'b0, 1'b0, 10, 12'd2245, 12'd2533);
  endtask

  task automatic test_to_eos();
    run_fill("to_eos", 3, 30, 0, 78, 7'h20, 1'b0, 1'b0, 1'b0, 82, 12'd2526, 12'h9FF);
  endtask

  task automatic test_rows_ignore_start();
    run_fill("rows", 2, 3, 4, 0, 7'h41, 1'b0, 1'b0, 1'b1, 160, 12'd3, 12'd2532);
  endtask

  task automatic test_backpressure();
    run_fill("backpressure", 0, 0, 0, 0, 7'h00, 1'b1, 1'b1, 1'b0, 2560, 12'h000, 12'h9FF);
  endtask

  task automatic test_empty();
    run_fill("empty_col", 1, 0, 0, 80, 7'h11, 1'b0, 1'b0, 1'b0, 0, 12'h000, 12'h000);
    run_fill("empty_rows", 2, 3, 2, 0, 7'h11, 1'b0, 1'b0, 1'b0, 0, 12'h000, 12'h000);
  endtask

  initial begin
    test_reset();
    test_full();
    test_line_tail();
    test_to_eos();
    test_rows_ignore_start();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    test_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/char_buffer_fill.md
# char_buffer_fill

Parametrised fill engine for the VGA text character buffer. It replaces the fixed 80x32 init/erase block with a request/acknowledge interface. It adds four region modes (full screen, line tail, row range, cursor to end of screen), constant or incrementing-pattern data, write back-pressure and abort. It sits between the terminal/escape-sequence controller and the character RAM write-port arbiter.

## Interface
Parameters:
- COLS, 80: columns per row.
- ROWS, 32: rows per screen; must be a power of two.
- DATA_W, 7: character code width.
- Derived localparams: COL_W=$clog2(COLS), ROW_W=$clog2(ROWS), ADDR_W=COL_W+ROW_W.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- mode  in  2  0 FULL, 1 LINE_TAIL, 2 ROWS, 3 TO_EOS.
- startRow  in  ROW_W  first row (modes 1–3).
- endRow  in  ROW_W  last row, inclusive (mode 2 only).
- startCol  in  COL_W  first column (modes 1 and 3).
- fillData  in  DATA_W  constant fill value.
- patternEn  in  1  1 selects incrementing data instead of fillData.
- abort  in  1  stops an active fill.
- wrReady  in  1  arbiter accepts the current write.
- wrEn  out  1  write request.
- wrAddr  out  ADDR_W  {col, row}.
- wrData  out  DATA_W  write data.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.

## Operation
- States: IDLE, RUN, DONE.
- Request capture:
  - IDLE with start=1 latches mode, rows, col, fillData and patternEn.
  - It loads the counters: col = startCol (modes 1, 3) else 0; row = startRow (modes 1–3) else 0.
  - Data counter: patternEn ? 0 : fillData.
- Transition from IDLE on start:
  - Valid request goes to RUN.
  - Empty request goes to DONE. A request is empty if startRow ≥ ROWS or startCol ≥ COLS (in modes that use them), or if mode 2 has endRow < startRow.
- RUN:
  - wrEn=1, wrAddr={col,row}, wrData=data.
  - A write is accepted when wrEn & wrReady. Counters advance only on acceptance. wrReady=0 holds address and data stable.
- Advance rule: col increments; at col==COLS-1, col goes to 0 and row increments, except in mode 1.
- Data rule: if patternEn, data increments modulo 2^DATA_W per accepted write; otherwise it is constant.
- Last write, by mode:
  - Mode 0 and mode 3: col==COLS-1 and row==ROWS-1.
  - Mode 1: col==COLS-1.
  - Mode 2: col==COLS-1 and row==endRow.
- Leaving RUN:
  - Last write accepted goes to DONE.
  - abort=1 goes to IDLE and takes priority over acceptance on the same cycle. That write still counts as written, and no done pulse is issued.
- DONE: done=1 for one cycle, then IDLE. start is ignored in RUN and DONE, with no queuing.
- Row arithmetic never wraps past ROWS-1; termination precedes overflow.

## Timing
- Reset values: state IDLE; wrEn, busy and done 0; wrAddr 0; wrData 0. A reset mid-fill aborts with no further writes and no done.
- start at cycle N: first wrEn at N+1.
- Throughput: one write per cycle with wrReady held high. N accepted writes take N cycles of RUN.
- Last write accepted at cycle M: done=1 at M+1, busy=0 at M+1.
- Empty request at cycle N: done=1 at N+1, with no wrEn.
- Earliest new start: the cycle after done (IDLE).
- Outputs are registered; there is no combinational path from wrReady to wrEn or wrAddr.

## Structure
- Package `vga_fill_pkg`: mode encodings (FILL_FULL, FILL_LINE_TAIL, FILL_ROWS, FILL_TO_EOS) and the state encoding.
- Sub-module `fill_region_counter`: holds the col/row counters with load, advance-on-accept and the last-position compare. It is parametrised by COLS and ROWS.
- The top level holds the FSM, the request latch and the data counter.

## Test plan
Defaults COLS=80, ROWS=32, DATA_W=7 unless stated.
- Mode 0, fillData=0, wrReady=1: 2560 writes; first address 0, last address 12'h9FF; done 2561 cycles after start.
- Mode 1, startRow=5, startCol=70, patternEn=1: 10 writes; addresses 2245, 2277, …, 2533; data 0–9; done follows.
- Mode 3, startRow=30, startCol=78: 82 writes, ending at {79,31}. Mode 2, rows 3–4: 160 writes.
- Mode 0 with wrReady toggling 1/0 each cycle: 2560 accepted writes, no duplicate or skipped addresses, address and data held while wrReady=0.
- Abort at the 100th RUN cycle: wrEn=0 the next cycle, no done; a new start then proceeds normally. Reset mid-fill gives the same result.
- startCol=80 in mode 1, or mode 2 with endRow=2 and startRow=3: zero writes, done at N+1. A start pulsed during RUN is ignored.
